mma_result_drain: RTL and testbench

//  Downstream stage of tensor_core_fp16_mma. Captures the FP32 D tile when the core pulses

---
 rtl/mma_result_drain_if.sv | 29 ++
 rtl/mma_result_drain.sv | 85 ++++++++
 tb/tb_mma_result_drain.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mma_result_drain_if.sv
// Handshake bundle between the MMA core, the result drain and the downstream consumer.
// slave = drain side, master = core/consumer side.
interface mma_result_drain_if #(
  parameter int M = 4,
  parameter int N = 4
);
  localparam int RW = $clog2(M);

  logic              result_valid;
  logic [31:0]       matrix_d [0:M*N-1];
  logic              drain_ready;
  logic              out_valid;
  logic              out_ready;
  logic [N*32-1:0]   out_data;
  logic [RW-1:0]     out_row;
  logic              out_last;
  logic              overrun;
  logic              clear_overrun;

  modport slave (
    input  result_valid, matrix_d, out_ready, clear_overrun,
    output drain_ready, out_valid, out_data, out_row, out_last, overrun
  );

  modport master (
    output result_valid, matrix_d, out_ready, clear_overrun,
    input  drain_ready, out_valid, out_data, out_row, out_last, overrun
  );
endinterface

// File: rtl/mma_result_drain.sv
// Captures an FP32 D tile from the MMA core and streams it out one row per valid/ready beat.
// Optional macro DRAIN_RELU_EN: clamp negative non-NaN words to +0.0 at capture time.
module mma_result_drain #(
  parameter int M = 4,
  parameter int N = 4
) (
  input logic               clk,
  input logic               rst_n,
  mma_result_drain_if.slave bus
);
  localparam int RW = $clog2(M);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t        state;
  logic [31:0]   buffer [0:M*N-1];
  logic [RW-1:0] row;
  logic          valid;
  logic          ovr;

  logic          last_row;
  logic          accept;
  logic          drain_ready;
  logic          capture;

  function automatic logic [31:0] xform_word(input logic [31:0] w);
`ifdef DRAIN_RELU_EN
    // NaNs keep their payload even when the sign bit is set
    if (w[31] && !((w[30:23] == 8'hFF) && (w[22:0] != 23'd0)))
      return 32'h0000_0000;
    else
      return w;
`else
    return w;
`endif
  endfunction

  assign last_row    = (row == RW'(M - 1));
  assign accept      = valid && bus.out_ready;
  assign drain_ready = (state == IDLE) || (accept && last_row);
  assign capture     = bus.result_valid && drain_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      valid <= 1'b0;
      row   <= '0;
      ovr   <= 1'b0;
      for (int i = 0; i < M*N; i++) buffer[i] <= 32'h0;
    end else begin
      // capture wins over the last-beat retire so back-to-back tiles have no idle cycle
      if (capture) begin
        for (int i = 0; i < M*N; i++) buffer[i] <= xform_word(bus.matrix_d[i]);
        row   <= '0;
        valid <= 1'b1;
        state <= STREAM;
      end else if (state == STREAM && accept) begin
        if (last_row) begin
          valid <= 1'b0;
          state <= IDLE;
        end else begin
          row <= row + RW'(1);
        end
      end

      if (bus.result_valid && !drain_ready)
        ovr <= 1'b1;
      else if (bus.clear_overrun)
        ovr <= 1'b0;
    end
  end

  // --- output stage: row mux of the captured tile ---
  always_comb begin
    bus.out_data = '0;
    for (int c = 0; c < N; c++)
      bus.out_data[c*32 +: 32] = buffer[int'(row)*N + c];
  end

  assign bus.drain_ready = drain_ready;
  assign bus.out_valid   = valid;
  assign bus.out_row     = row;
  assign bus.out_last    = valid && last_row;
  assign bus.overrun     = ovr;
endmodule

// File: tb/tb_mma_result_drain.sv
// Randomized self-checking bench for mma_result_drain using a row-queue reference model.
module tb_mma_result_drain;
  localparam int M  = 4;
  localparam int N  = 4;
  localparam int RW = $clog2(M);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mma_result_drain_if #(.M(M), .N(N)) bus();
  mma_result_drain #(.M(M), .N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  int total = 0;
  int bad   = 0;

  logic [31:0]     tile [0:M*N-1];
  logic [N*32-1:0] exp_data [$];
  int              exp_row  [$];

  function automatic logic [31:0] fp32_of_int(input int i);
    real r;
    logic [63:0] b;
    logic [10:0] e;
    if (i == 0) return 32'h0;
    r = i;
    b = $realtobits(r);
    e = b[62:52] - 11'd896;
    return {b[63], e[7:0], b[51:29]};
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] w);
    logic is_nan;
    is_nan = (w[30:23] == 8'hFF) && (w[22:0] != 23'd0);
`ifdef DRAIN_RELU_EN
    if (w[31] && !is_nan) return 32'h0;
`endif
    return w;
  endfunction

  task automatic random_tile();
    for (int i = 0; i < M*N; i++) tile[i] = $urandom;
  endtask

  // drives result_valid with the current tile; when a capture is expected the model learns its rows
  task automatic offer_tile(input bit expect_capture);
    logic [N*32-1:0] d;
    for (int i = 0; i < M*N; i++) bus.matrix_d[i] = tile[i];
    bus.result_valid = 1'b1;
    if (expect_capture) begin
      for (int r = 0; r < M; r++) begin
        for (int c = 0; c < N; c++) d[c*32 +: 32] = ref_word(tile[r*N + c]);
        exp_data.push_back(d);
        exp_row.push_back(r);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.result_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.clear_overrun = 1'b0;
    for (int i = 0; i < M*N; i++) bus.matrix_d[i] = 32'h0;
    repeat (5) @(negedge clk);
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b exp=0", bus.overrun); end
    total++; if (bus.drain_ready !== 1'b1) begin bad++; $display("FAIL reset_drain_ready got=%b exp=1", bus.drain_ready); end
    total++; if (bus.out_row !== RW'(0)) begin bad++; $display("FAIL reset_row got=%0d exp=0", bus.out_row); end
    total++; if (bus.out_last !== 1'b0) begin bad++; $display("FAIL reset_last got=%b exp=0", bus.out_last); end
    total++; if (bus.out_data !== '0) begin bad++; $display("FAIL reset_data got=%h exp=0", bus.out_data); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_tile();
    int cyc;
    for (int i = 0; i < M*N; i++) tile[i] = fp32_of_int(i);
    @(negedge clk);
    offer_tile(1'b1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.result_valid = 1'b0;
    cyc = 0;
    while (exp_row.size() > 0 && cyc < 20) begin
      #1;
      total++;
      if (bus.out_valid !== 1'b1) begin
        bad++; $display("FAIL single_valid cyc=%0d got=%b exp=1", cyc, bus.out_valid);
      end else begin
        if (bus.out_data !== exp_data[0]) begin bad++; $display("FAIL single_data row=%0d got=%h exp=%h", exp_row[0], bus.out_data, exp_data[0]); end
        total++; if (bus.out_row !== RW'(exp_row[0])) begin bad++; $display("FAIL single_row got=%0d exp=%0d", bus.out_row, exp_row[0]); end
        total++; if (bus.out_last !== (exp_row[0] == M-1)) begin bad++; $display("FAIL single_last got=%b exp=%b", bus.out_last, exp_row[0] == M-1); end
        if (exp_row[0] == 1) begin
          total++; if (bus.out_data[31:0] !== 32'h4080_0000) begin bad++; $display("FAIL single_row1_word0 got=%h exp=40800000", bus.out_data[31:0]); end
        end
        void'(exp_data.pop_front()); void'(exp_row.pop_front());
      end
      @(negedge clk);
      cyc++;
    end
    #1;
    total++; if (cyc != M || exp_row.size() != 0) begin bad++; $display("FAIL single_beats got=%0d exp=%0d", cyc, M); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL single_idle_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.drain_ready !== 1'b1) begin bad++; $display("FAIL single_idle_ready got=%b exp=1", bus.drain_ready); end
    exp_data.delete(); exp_row.delete();
  endtask

  task automatic test_backpressure();
    int k, beats;
    bit stalled;
    logic [N*32-1:0] held_data;
    logic [RW-1:0]   held_row;
    random_tile();
    @(negedge clk);
    offer_tile(1'b1);
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.result_valid = 1'b0;
    k = 0; beats = 0; stalled = 1'b0;
    held_data = '0; held_row = '0;
    while (exp_row.size() > 0 && k < 40) begin
      bus.out_ready = (k % 3 == 0);
      #1;
      if (stalled) begin
        total++; if (bus.out_data !== held_data) begin bad++; $display("FAIL bp_hold_data got=%h exp=%h", bus.out_data, held_data); end
        total++; if (bus.out_row !== held_row) begin bad++; $display("FAIL bp_hold_row got=%0d exp=%0d", bus.out_row, held_row); end
      end
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid got=%b exp=1", bus.out_valid); end
      total++; if (bus.out_data !== exp_data[0]) begin bad++; $display("FAIL bp_data got=%h exp=%h", bus.out_data, exp_data[0]); end
      total++; if (bus.out_row !== RW'(exp_row[0])) begin bad++; $display("FAIL bp_row got=%0d exp=%0d", bus.out_row, exp_row[0]); end
      if (bus.out_ready) begin
        void'(exp_data.pop_front()); void'(exp_row.pop_front());
        beats++; stalled = 1'b0;
      end else begin
        stalled = 1'b1; held_data = bus.out_data; held_row = bus.out_row;
      end
      @(negedge clk);
      k++;
    end
    bus.out_ready = 1'b0;
    #1;
    total++; if (beats != M) begin bad++; $display("FAIL bp_beats got=%0d exp=%0d", beats, M); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_end_valid got=%b exp=0", bus.out_valid); end
    exp_data.delete(); exp_row.delete();
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit sent;
    random_tile();
    @(negedge clk);
    offer_tile(1'b1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.result_valid = 1'b0;
    cyc = 0; sent = 1'b0;
    while (exp_row.size() > 0 && cyc < 30) begin
      bus.result_valid = 1'b0;
      if (!sent && exp_row.size() == 1) begin
        random_tile();
        offer_tile(1'b1);
        sent = 1'b1;
        #1;
        total++; if (bus.drain_ready !== 1'b1) begin bad++; $display("FAIL b2b_drain_ready got=%b exp=1", bus.drain_ready); end
      end else begin
        #1;
      end
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid cyc=%0d got=%b exp=1", cyc, bus.out_valid); end
      total++; if (bus.out_data !== exp_data[0]) begin bad++; $display("FAIL b2b_data got=%h exp=%h", bus.out_data, exp_data[0]); end
      total++; if (bus.out_row !== RW'(exp_row[0])) begin bad++; $display("FAIL b2b_row got=%0d exp=%0d", bus.out_row, exp_row[0]); end
      void'(exp_data.pop_front()); void'(exp_row.pop_front());
      @(negedge clk);
      cyc++;
    end
    bus.result_valid = 1'b0;
    #1;
    total++; if (cyc != 2*M) begin bad++; $display("FAIL b2b_beats got=%0d exp=%0d", cyc, 2*M); end
    total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL b2b_overrun got=%b exp=0", bus.overrun); end
    exp_data.delete(); exp_row.delete();
  endtask

  task automatic test_overrun();
    int cyc;
    bit sent;
    random_tile();
    @(negedge clk);
    offer_tile(1'b1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.result_valid = 1'b0;
    cyc = 0; sent = 1'b0;
    while (exp_row.size() > 0 && cyc < 20) begin
      bus.result_valid = 1'b0;
      if (!sent && exp_row.size() == M-1) begin
        random_tile();
        offer_tile(1'b0);
        sent = 1'b1;
        #1;
        total++; if (bus.drain_ready !== 1'b0) begin bad++; $display("FAIL ovr_drain_ready got=%b exp=0", bus.drain_ready); end
      end else begin
        #1;
      end
      total++; if (bus.out_data !== exp_data[0]) begin bad++; $display("FAIL ovr_data got=%h exp=%h", bus.out_data, exp_data[0]); end
      total++; if (bus.out_row !== RW'(exp_row[0])) begin bad++; $display("FAIL ovr_row got=%0d exp=%0d", bus.out_row, exp_row[0]); end
      void'(exp_data.pop_front()); void'(exp_row.pop_front());
      @(negedge clk);
      cyc++;
    end
    bus.result_valid = 1'b0;
    #1;
    total++; if (bus.overrun !== 1'b1) begin bad++; $display("FAIL ovr_set got=%b exp=1", bus.overrun); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL ovr_end_valid got=%b exp=0", bus.out_valid); end
    @(negedge clk);
    bus.clear_overrun = 1'b1;
    @(negedge clk);
    bus.clear_overrun = 1'b0;
    #1;
    total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b exp=0", bus.overrun); end

    // set and clear in the same cycle while a stalled stream holds the buffer
    random_tile();
    @(negedge clk);
    offer_tile(1'b1);
    bus.out_ready = 1'b0;
    @(negedge clk);
    random_tile();
    offer_tile(1'b0);
    bus.clear_overrun = 1'b1;
    @(negedge clk);
    bus.result_valid = 1'b0;
    bus.clear_overrun = 1'b0;
    #1;
    total++; if (bus.overrun !== 1'b1) begin bad++; $display("FAIL ovr_set_priority got=%b exp=1", bus.overrun); end
    total++; if (bus.out_data !== exp_data[0]) begin bad++; $display("FAIL ovr_kept_data got=%h exp=%h", bus.out_data, exp_data[0]); end
    total++; if (bus.out_row !== RW'(0)) begin bad++; $display("FAIL ovr_kept_row got=%0d exp=0", bus.out_row); end
    @(negedge clk);
    bus.out_ready = 1'b1;
    cyc = 0;
    while (exp_row.size() > 0 && cyc < 20) begin
      #1;
      total++; if (bus.out_data !== exp_data[0]) begin bad++; $display("FAIL ovr_drain_data got=%h exp=%h", bus.out_data, exp_data[0]); end
      void'(exp_data.pop_front()); void'(exp_row.pop_front());
      @(negedge clk);
      cyc++;
    end
    bus.clear_overrun = 1'b1;
    @(negedge clk);
    bus.clear_overrun = 1'b0;
    exp_data.delete(); exp_row.delete();
  endtask

  task automatic test_relu();
    int cyc;
    logic [127:0] exp_row0;
`ifdef DRAIN_RELU_EN
    exp_row0 = {32'hFFC0_0000, 32'h4000_0000, 32'h0000_0000, 32'h0000_0000};
`else
    exp_row0 = {32'hFFC0_0000, 32'h4000_0000, 32'h8000_0000, 32'hBFC0_0000};
`endif
    random_tile();
    tile[0] = 32'hBFC0_0000;
    tile[1] = 32'h8000_0000;
    tile[2] = 32'h4000_0000;
    tile[3] = 32'hFFC0_0000;
    @(negedge clk);
    offer_tile(1'b1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.result_valid = 1'b0;
    #1;
    total++; if (bus.out_data[127:0] !== exp_row0) begin bad++; $display("FAIL relu_row0 got=%h exp=%h", bus.out_data[127:0], exp_row0); end
    cyc = 0;
    while (exp_row.size() > 0 && cyc < 20) begin
      if (cyc > 0) #1;
      total++; if (bus.out_data !== exp_data[0]) begin bad++; $display("FAIL relu_data row=%0d got=%h exp=%h", exp_row[0], bus.out_data, exp_data[0]); end
      void'(exp_data.pop_front()); void'(exp_row.pop_front());
      @(negedge clk);
      cyc++;
    end
    total++; if (exp_row.size() != 0) begin bad++; $display("FAIL relu_timeout left=%0d exp=0", exp_row.size()); end

    // asynchronous reset in the middle of a stream
    random_tile();
    offer_tile(1'b1);
    @(negedge clk);
    bus.result_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.out_row !== RW'(0)) begin bad++; $display("FAIL rst_mid_row got=%0d exp=0", bus.out_row); end
    total++; if (bus.out_data !== '0) begin bad++; $display("FAIL rst_mid_data got=%h exp=0", bus.out_data); end
    total++; if (bus.drain_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_drain_ready got=%b exp=1", bus.drain_ready); end
    exp_data.delete(); exp_row.delete();
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_tile();
    test_backpressure();
    test_back_to_back();
    test_overrun();
    test_relu();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
